// File: rtl/linebuffer3x3_stream_if.sv
// Pixel-in / stencil-out stream bundle for the 3x3 line buffer.
interface linebuffer3x3_stream_if #(
    parameter int DW = 8
);
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [9*DW-1:0] out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/linebuffer3x3_stream.sv
// Streaming 3x3 line buffer: raster pixels in, one stencil per full window out.
// Optional frame-length check and in_last resync: define LB_LAST_CHECK_EN.
module linebuffer3x3_stream #(
    parameter int IMG_W = 260,
    parameter int IMG_H = 258,
    parameter int DW    = 8
) (
    input  logic clk,
    input  logic reset,
    linebuffer3x3_stream_if.slave s,
    output logic err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];

    // win[r][0] / win[r][1] hold columns col-2 / col-1 for the next pixel
    logic [DW-1:0] win [3][2];

    logic [DW-1:0]   rd0;
    logic [DW-1:0]   rd1;
    logic            accept;
    logic            emit;
    logic            at_end;
    logic            wrap;
    logic [9*DW-1:0] nxt_data;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;

    assign rd0    = lb0[col];
    assign rd1    = lb1[col];
    assign at_end = (col == COL_MAX) && (row == ROW_MAX);
    assign emit   = (col >= CW'(2)) && (row >= RW'(2));

`ifdef LB_LAST_CHECK_EN
    assign wrap = at_end || s.in_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && (s.in_last != at_end)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_last;

    assign wrap        = at_end;
    assign unused_last = s.in_last;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (wrap) begin
                col <= '0;
                row <= '0;
            end else if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= rd1;
            lb1[col] <= s.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
            end
            win[0][1] <= rd0;
            win[1][1] <= rd1;
            win[2][1] <= s.in_data;
        end
    end

    always_comb begin
        nxt_data = '0;
        for (int r = 0; r < 3; r++) begin
            nxt_data[DW*(3*r)   +: DW] = win[r][0];
            nxt_data[DW*(3*r+1) +: DW] = win[r][1];
        end
        nxt_data[DW*2 +: DW] = rd0;
        nxt_data[DW*5 +: DW] = rd1;
        nxt_data[DW*8 +: DW] = s.in_data;
    end

    // Reload on emit even while the old stencil is leaving this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            s.out_valid <= 1'b0;
            s.out_last  <= 1'b0;
            s.out_data  <= '0;
        end else if (accept && emit) begin
            s.out_valid <= 1'b1;
            s.out_last  <= at_end;
            s.out_data  <= nxt_data;
        end else if (s.out_ready) begin
            s.out_valid <= 1'b0;
            s.out_last  <= 1'b0;
        end
    end
endmodule

// File: doc/linebuffer3x3_stream.md
# linebuffer3x3_stream

Streaming 3x3 line buffer that accepts raster-order 8-bit pixels on a valid/ready/last interface and emits one 3x3 stencil for every input pixel that completes a full window. It sits directly downstream of the blur pipeline's pixel input stream and feeds the 3x3 blur compute stage. It stores two full image rows and keeps a 3-column window register. Output geometry is (IMG_W-2) x (IMG_H-2) stencils per frame.

## Interface
- IMG_W, 260, pixels per row (>=3)
- IMG_H, 258, rows per frame (>=3)
- DW, 8, pixel width in bits
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  DW  pixel
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final pixel of a frame
- in_ready  out  1  block accepts a pixel this cycle
- out_data  out  9*DW  stencil; lane k = out_data[DW*k +: DW], k = 3*r+c
- out_valid  out  1  stencil valid
- out_last  out  1  final stencil of a frame
- out_ready  in  1  consumer accepts the stencil
- err  out  1  sticky frame-length mismatch flag

## Operation
- Accept a pixel when in_valid && in_ready. Only accepted pixels advance state.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel being accepted. col wraps to 0 and increments row. Both counters wrap to 0 after (IMG_W-1, IMG_H-1).
- Line memories lb0 and lb1 are each IMG_W x DW. lb1[col] holds row-1 and lb0[col] holds row-2.
- On accept:
  - Read both memories at col, returning the old values.
  - Write lb0[col] <= lb1[col] and lb1[col] <= in_data.
  - Shift the column {lb0[col], lb1[col], in_data} into the window as column c=2. The old c=2 becomes c=1, and the old c=1 becomes c=0.
- Lane mapping: lane (r,c) = pixel at (row-2+r, col-2+c). Lane 8 is therefore the newest pixel.
- A stencil is emitted when the accepted pixel has col>=2 && row>=2.
- out_last = 1 on the stencil emitted for (IMG_W-1, IMG_H-1).
- Memories and window registers are not reset. The emit rule guarantees that stale contents are never visible.
- in_ready = !out_valid || out_ready. This is a single output register with no skid buffer. A stencil is never dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, err=0, col=0, row=0. in_ready=1 during and after reset.
- Latency: the stencil is registered. out_valid rises on the cycle after the completing pixel is accepted.
- out_data and out_last hold stable while out_valid && !out_ready.
- Full throughput is one pixel per cycle when out_ready=1. Simultaneous handshakes are allowed:
  - An out handshake together with an emitting in-accept reloads the output register in the same cycle.
  - An out handshake with a non-emitting accept clears out_valid.
- Reset mid-frame returns to frame start at the next cycle and discards the pending stencil. Line memory contents are ignored.
- Back-to-back frames need no idle cycle. The pixel after the last pixel is (0,0) of the next frame.

## Configuration
- LB_LAST_CHECK_EN defined:
  - On an accepted pixel, err is set (sticky until reset) if in_last != (col==IMG_W-1 && row==IMG_H-1).
  - An accepted in_last also forces col=row=0 for the next pixel, resynchronising the frame.
- LB_LAST_CHECK_EN undefined:
  - in_last is ignored and err is tied to 0.
  - Frame boundaries come from the counters only.

## Test plan
- Full frame without stalls: 260x258 frame with pixel=(x+y)&255 and out_ready=1.
  - Exactly 66048 stencils.
  - The first stencil has lanes 0..8 = 0,1,2,1,2,3,2,3,4.
  - out_last is set only on the 66048th stencil, whose lane 8 = (259+257)&255 = 4.
- Random stalls: random in_valid gaps of 1-32 cycles plus random out_ready.
  - The stencil sequence is identical to the no-stall run; a scoreboard against a software 3x3 window model shows no drops or duplicates.
- Output backpressure: hold out_ready=0 from start.
  - After the first stencil, in_ready=0 and out_data is stable.
  - Releasing out_ready for one cycle accepts exactly one further pixel.
- Early in_last (LB_LAST_CHECK_EN): assert in_last at pixel (10,5).
  - err=1 and stays 1.
  - The next pixel is treated as (0,0).
  - The build without the macro keeps err=0 and continues counting.
- Reset mid-frame: pulse reset after 1000 pixels, then send a full frame.
  - out_valid=0 the cycle after reset.
  - The output matches the clean full-frame run.
- Back-to-back frames: send two frames without a gap.
  - Two out_last pulses, 66048 stencils apart.
  - The second frame's first stencil contains only second-frame pixels.
